tick_generator: RTL and testbench

Multi-channel, runtime-programmable clock/tick divider. Each of `NUM_CH` channels divides the system clock by its own `WIDTH`-bit divisor. Each channel produces a single-cycle `tick` enable and a 50%-duty square-wave `clk_out`. Downstream timing logic (seconds counters, display refresh, debounce sampling) uses it in place of fixed single-rate dividers. Divisor changes are glitch-free: they take effect at a terminal count.

---
 rtl/tick_generator.sv | 162 ++++++++++++++++
 tb/tb_tick_generator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_generator.sv
// ---------------------------------------------------------------------------
// tick_generator
//
// Multi-channel, runtime-programmable clock divider. Each channel divides clk
// by its own WIDTH-bit divisor D and produces:
//   - tick    : one-cycle enable pulse every D cycles
//   - clk_out : 50%-duty square wave of period 2*D (toggles on every tick)
//   - pending : a new divisor has been captured but is not active yet
//
// Divisor changes made while a channel is counting are held in a shadow
// register and applied at the next terminal count, so no short or long
// period is ever produced.
//
// Ports
//   clk      in   system clock, all logic on the rising edge
//   rst      in   synchronous active-high reset
//   sync     in   phase-align strobe, restarts every channel at once
//   en       in   [NUM_CH]        per-channel count enable
//   load     in   [NUM_CH]        per-channel divisor load strobe
//   div_in   in   [NUM_CH*WIDTH]  packed divisors, channel i at [i*WIDTH +: WIDTH]
//   tick     out  [NUM_CH]        registered one-cycle tick
//   clk_out  out  [NUM_CH]        registered square wave
//   pending  out  [NUM_CH]        registered shadow-valid flag
//
// Strobe semantics: load and sync are single-cycle strobes sampled on every
// rising edge while high. There is no backpressure; a load is always
// accepted, and a later load overwrites an earlier one that is still
// pending (last load wins).
// ---------------------------------------------------------------------------
module tick_generator #(
    parameter int          NUM_CH      = 4,
    parameter int          WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] div_in,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       pending
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Registered per-channel state
    logic [WIDTH-1:0]  cnt_q    [NUM_CH];
    logic [WIDTH-1:0]  div_q    [NUM_CH];
    logic [WIDTH-1:0]  shadow_q [NUM_CH];
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] pend_q;

    // Next-state values
    logic [WIDTH-1:0]  cnt_d    [NUM_CH];
    logic [WIDTH-1:0]  div_d    [NUM_CH];
    logic [WIDTH-1:0]  shadow_d [NUM_CH];
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] pend_d;

    // Per-channel decode
    logic [NUM_CH-1:0] active;     // D != 0
    logic [NUM_CH-1:0] tc;         // terminal count this edge
    logic [WIDTH-1:0]  last_cnt [NUM_CH];
    logic [WIDTH-1:0]  div_slice [NUM_CH];

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        tick_d    = tick_q;
        clk_d     = clk_q;
        pend_d    = pend_q;
        active    = '0;
        tc        = '0;
        last_cnt  = cnt_q;
        div_slice = cnt_q;

        for (int i = 0; i < NUM_CH; i++) begin
            div_slice[i] = div_in[i*WIDTH +: WIDTH];
            active[i]    = (div_q[i] != '0);
            // D-1 is only formed for a non-zero divisor, so it never wraps.
            last_cnt[i]  = active[i] ? (div_q[i] - ONE) : '0;
            tc[i]        = en[i] && active[i] && (cnt_q[i] == last_cnt[i]);

            if (sync) begin
                // Restart every channel in phase; flush any deferred divisor,
                // with a same-cycle load taking precedence over the shadow.
                cnt_d[i]  = '0;
                tick_d[i] = 1'b0;
                clk_d[i]  = 1'b1;
                pend_d[i] = 1'b0;
                if (load[i]) begin
                    div_d[i] = div_slice[i];
                end else if (pend_q[i]) begin
                    div_d[i] = shadow_q[i];
                end
            end else if (tc[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                clk_d[i]  = ~clk_q[i];
                pend_d[i] = 1'b0;
                // A load landing on the TC edge wins over the older shadow
                // and takes effect for the period that starts now.
                if (load[i]) begin
                    div_d[i] = div_slice[i];
                end else if (pend_q[i]) begin
                    div_d[i] = shadow_q[i];
                end
            end else if (en[i] && active[i]) begin
                cnt_d[i]  = cnt_q[i] + ONE;
                tick_d[i] = 1'b0;
                // Mid-period load: park it until the current period ends.
                if (load[i]) begin
                    shadow_d[i] = div_slice[i];
                    pend_d[i]   = 1'b1;
                end
            end else begin
                // Disabled or idle (D=0): count and clk_out hold.
                tick_d[i] = 1'b0;
                if (!active[i]) begin
                    cnt_d[i] = '0;
                end
                // Nothing is counting, so a new divisor can apply at once.
                if (load[i]) begin
                    div_d[i]  = div_slice[i];
                    cnt_d[i]  = '0;
                    pend_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                div_q[i]    <= DEF_DIV;
                shadow_q[i] <= DEF_DIV;
            end
            tick_q <= '0;
            clk_q  <= '1;
            pend_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            tick_q   <= tick_d;
            clk_q    <= clk_d;
            pend_q   <= pend_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_tick_generator.sv
// ---------------------------------------------------------------------------
// tb_tick_generator
//
// Directed bench for tick_generator. Main instance: NUM_CH=4, WIDTH=8,
// DEFAULT_DIV=4. A second single-channel instance with WIDTH=4 and
// DEFAULT_DIV=15 exercises the full-width divisor. Inputs change 1 time
// unit after each rising edge; outputs are read at the same point, so the
// value seen after "edge e" is the value registered on that edge.
// ---------------------------------------------------------------------------
module tb_tick_generator;

    localparam int NCH = 4;
    localparam int W   = 8;

    // Clock / reset block
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT signals
    logic                 sync;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       load;
    logic [NCH*W-1:0]     div_in;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       pending;

    // Narrow DUT signals
    logic [0:0]           en2;
    logic [0:0]           load2;
    logic [3:0]           div2;
    logic [0:0]           tick2;
    logic [0:0]           clk_out2;
    logic [0:0]           pending2;

    tick_generator #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .sync    (sync),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .tick    (tick),
        .clk_out (clk_out),
        .pending (pending)
    );

    tick_generator #(.NUM_CH(1), .WIDTH(4), .DEFAULT_DIV(15)) dut_w4 (
        .clk     (clk),
        .rst     (rst),
        .sync    (1'b0),
        .en      (en2),
        .load    (load2),
        .div_in  (div2),
        .tick    (tick2),
        .clk_out (clk_out2),
        .pending (pending2)
    );

    // Scoreboard counters
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        sync   = 1'b0;
        en     = '0;
        load   = '0;
        div_in = '0;
        en2    = '0;
        load2  = '0;
        div2   = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Immediate load: channel disabled for the load edge.
    task automatic load_imm(input int ch, input logic [W-1:0] val);
        en[ch]             = 1'b0;
        load[ch]           = 1'b1;
        div_in[ch*W +: W]  = val;
        step();
        load[ch]           = 1'b0;
    endtask

    initial begin
        // ---------------- Reset and free-run ----------------
        reset_dut();
        check_eq("reset tick", 32'(tick), 32'(4'b0000));
        check_eq("reset clk_out", 32'(clk_out), 32'(4'b1111));
        check_eq("reset pending", 32'(pending), 32'(4'b0000));
        en = '1;
        for (int e = 1; e <= 12; e++) begin
            step();
            check_eq($sformatf("free tick e%0d", e), 32'(tick), (e % 4 == 0) ? 32'hF : 32'h0);
            check_eq($sformatf("free clk_out e%0d", e), 32'(clk_out),
                     (e < 4 || (e >= 8 && e < 12)) ? 32'hF : 32'h0);
            check_eq($sformatf("free pending e%0d", e), 32'(pending), 32'h0);
        end

        // ---------------- Deferred load: D=10, load 3 at cnt=2 ----------------
        reset_dut();
        load_imm(0, 8'd10);
        en[0] = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            load[0]      = (e == 3);
            div_in[0 +: W] = 8'd3;
            step();
            check_eq($sformatf("defer pending e%0d", e), 32'(pending[0]),
                     (e >= 3 && e < 10) ? 32'd1 : 32'd0);
            check_eq($sformatf("defer tick e%0d", e), 32'(tick[0]),
                     (e == 10 || e == 13 || e == 16 || e == 19) ? 32'd1 : 32'd0);
        end
        load = '0;

        // ---------------- Load on TC, then two loads in one period ----------------
        reset_dut();
        en[0] = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            load[0] = (e == 4 || e == 16 || e == 18);
            div_in[0 +: W] = (e == 4) ? 8'd5 : (e == 16) ? 8'd7 : 8'd6;
            step();
            check_eq($sformatf("tcload tick e%0d", e), 32'(tick[0]),
                     (e == 4 || e == 9 || e == 14 || e == 19 || e == 25 || e == 31) ? 32'd1 : 32'd0);
            check_eq($sformatf("tcload pending e%0d", e), 32'(pending[0]),
                     (e >= 16 && e <= 18) ? 32'd1 : 32'd0);
        end
        load = '0;

        // ---------------- Disable for 20 cycles, idle, then D=2 ----------------
        reset_dut();
        for (int e = 1; e <= 36; e++) begin
            en[1] = !(e >= 11 && e <= 30);
            step();
            check_eq($sformatf("freeze tick e%0d", e), 32'(tick[1]),
                     (e == 4 || e == 8 || e == 32 || e == 36) ? 32'd1 : 32'd0);
            check_eq($sformatf("freeze clk_out e%0d", e), 32'(clk_out[1]),
                     ((e >= 4 && e < 8) || (e >= 32 && e < 36)) ? 32'd0 : 32'd1);
        end
        load_imm(1, 8'd0);
        en[1] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            check_eq($sformatf("idle tick e%0d", e), 32'(tick[1]), 32'd0);
            check_eq($sformatf("idle clk_out e%0d", e), 32'(clk_out[1]), 32'd1);
        end
        load[1] = 1'b1;
        div_in[1*W +: W] = 8'd2;
        step();
        load[1] = 1'b0;
        check_eq("d2 load pending", 32'(pending[1]), 32'd0);
        for (int e = 1; e <= 8; e++) begin
            step();
            check_eq($sformatf("d2 tick e%0d", e), 32'(tick[1]), (e % 2 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("d2 clk_out e%0d", e), 32'(clk_out[1]),
                     ((e / 2) % 2 == 0) ? 32'd1 : 32'd0);
        end

        // ---------------- Sync aligns D=3 and D=6 ----------------
        reset_dut();
        load_imm(2, 8'd3);
        load_imm(3, 8'd6);
        en[2] = 1'b1;
        repeat (5) step();
        en[3] = 1'b1;
        repeat (4) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_eq("sync clk_out", 32'(clk_out[3:2]), 32'(2'b11));
        check_eq("sync tick", 32'(tick[3:2]), 32'(2'b00));
        for (int e = 1; e <= 12; e++) begin
            step();
            check_eq($sformatf("sync ch2 tick e%0d", e), 32'(tick[2]), (e % 3 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("sync ch3 tick e%0d", e), 32'(tick[3]), (e % 6 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("sync ch2 clk e%0d", e), 32'(clk_out[2]), ((e / 3) % 2 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("sync ch3 clk e%0d", e), 32'(clk_out[3]), ((e / 6) % 2 == 0) ? 32'd1 : 32'd0);
        end

        // ---------------- Reset while a load is pending ----------------
        en = 4'b0001;
        load[0] = 1'b1;
        div_in[0 +: W] = 8'd9;
        step();
        load[0] = 1'b0;
        check_eq("rstpend pending before", 32'(pending[0]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rstpend pending after", 32'(pending[0]), 32'd0);
        check_eq("rstpend clk_out", 32'(clk_out[0]), 32'd1);
        for (int e = 1; e <= 8; e++) begin
            step();
            check_eq($sformatf("rstpend tick e%0d", e), 32'(tick[0]), (e % 4 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("rstpend pending e%0d", e), 32'(pending[0]), 32'd0);
        end

        // ---------------- D=1 ----------------
        reset_dut();
        load_imm(0, 8'd1);
        en[0] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            check_eq($sformatf("d1 tick e%0d", e), 32'(tick[0]), 32'd1);
            check_eq($sformatf("d1 clk_out e%0d", e), 32'(clk_out[0]), (e % 2 == 0) ? 32'd1 : 32'd0);
        end

        // ---------------- WIDTH=4, D=15 ----------------
        en  = '0;
        en2 = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            step();
            check_eq($sformatf("w4 tick e%0d", e), 32'(tick2), (e == 15 || e == 30) ? 32'd1 : 32'd0);
            check_eq($sformatf("w4 clk_out e%0d", e), 32'(clk_out2),
                     (e >= 15 && e < 30) ? 32'd0 : 32'd1);
        end

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
